// File: rtl/math_subtractor_pipelined_cla_if.sv
// Operand/result handshake bundle for math_subtractor_pipelined_cla.
//   slave  : the subtractor side (takes operands, returns results)
//   master : the producer/consumer side driving operands and i_ready
// Signals:
//   i_valid/o_ready            operand beat handshake
//   i_a, i_b, i_borrow         minuend, subtrahend, borrow-in
//   o_valid/i_ready            result beat handshake
//   o_diff, o_borrow, o_overflow  difference, unsigned borrow-out, signed overflow
interface math_subtractor_pipelined_cla_if #(
    parameter int N = 32
) ();
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         i_borrow;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_diff;
    logic         o_borrow;
    logic         o_overflow;

    modport slave (
        input  i_valid, i_a, i_b, i_borrow, i_ready,
        output o_ready, o_valid, o_diff, o_borrow, o_overflow
    );

    modport master (
        output i_valid, i_a, i_b, i_borrow, i_ready,
        input  o_ready, o_valid, o_diff, o_borrow, o_overflow
    );
endinterface

// File: rtl/math_subtractor_pipelined_cla.sv
// Pipelined N-bit subtractor: o_diff = (i_a - i_b - i_borrow) mod 2^N.
// The word is split into CHUNK-bit slices; stage s resolves slice s with a
// carry-lookahead chain on a + ~b + ~borrow, using the carry registered by
// stage s-1. Upper operand bits ride along (skew) and finished lower diff bits
// are carried forward (deskew) so the last stage holds the complete result.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset, clears every stage
//   bus    slave side of math_subtractor_pipelined_cla_if
// Flow control is a single global enable: the whole pipe advances when the
// output register is empty or being drained, otherwise everything holds.
module math_subtractor_pipelined_cla #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    math_subtractor_pipelined_cla_if.slave bus
);
    localparam int STAGES = (CHUNK >= 1) ? N / CHUNK : 1;

    generate
        if (CHUNK < 1) begin : g_cfg_chunk
            $error("math_subtractor_pipelined_cla: CHUNK must be >= 1");
        end else if (N % CHUNK != 0) begin : g_cfg_div
            $error("math_subtractor_pipelined_cla: N must be a multiple of CHUNK");
        end
    endgenerate

    // One CHUNK-bit slice of a + nb + cin.
    // Returns {carry out of slice, carry_in(top) ^ carry_out(top), diff bits};
    // the middle bit is the signed-overflow flag when this is the top slice.
    function automatic logic [CHUNK+1:0] cla_slice(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] nb,
        input logic             cin
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] d;
        logic [CHUNK:0]   c;
        g    = a & nb;
        p    = a | nb;
        c    = '0;
        d    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            d[i]   = a[i] ^ nb[i] ^ c[i];
        end
        return {c[CHUNK], c[CHUNK] ^ c[CHUNK-1], d};
    endfunction

    // Stage registers. borrow_reg holds the inverted slice carry so that the
    // reset value (0) already matches the required o_borrow reset value.
    logic         valid_reg  [STAGES];
    logic [N-1:0] a_reg      [STAGES];
    logic [N-1:0] nb_reg     [STAGES];
    logic [N-1:0] diff_reg   [STAGES];
    logic         borrow_reg [STAGES];
    logic         ovf_reg    [STAGES];

    // Per-stage inputs and computed next values.
    logic         src_valid [STAGES];
    logic [N-1:0] src_a     [STAGES];
    logic [N-1:0] src_nb    [STAGES];
    logic [N-1:0] src_diff  [STAGES];
    logic         src_cin   [STAGES];
    logic [N-1:0] diff_next [STAGES];
    logic         cout_next [STAGES];
    logic         ovf_next  [STAGES];

    logic en;

    assign en          = bus.i_ready | ~valid_reg[STAGES-1];
    assign bus.o_ready = en;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CHUNK+1:0] slice_res;

            if (gi == 0) begin : g_src
                assign src_valid[gi] = bus.i_valid;
                assign src_a[gi]     = bus.i_a;
                assign src_nb[gi]    = ~bus.i_b;
                assign src_diff[gi]  = '0;
                assign src_cin[gi]   = ~bus.i_borrow;
            end else begin : g_src
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_a[gi]     = a_reg[gi-1];
                assign src_nb[gi]    = nb_reg[gi-1];
                assign src_diff[gi]  = diff_reg[gi-1];
                assign src_cin[gi]   = ~borrow_reg[gi-1];
            end

            assign slice_res = cla_slice(src_a[gi][gi*CHUNK +: CHUNK],
                                         src_nb[gi][gi*CHUNK +: CHUNK],
                                         src_cin[gi]);

            // Diff bits at and above this slice are still zero in src_diff,
            // so OR-ing the new slice in place is sufficient.
            assign diff_next[gi] = src_diff[gi]
                                 | (N'(slice_res[CHUNK-1:0]) << (gi * CHUNK));
            assign cout_next[gi] = slice_res[CHUNK+1];
            assign ovf_next[gi]  = slice_res[CHUNK];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_reg[s]  <= 1'b0;
                a_reg[s]      <= '0;
                nb_reg[s]     <= '0;
                diff_reg[s]   <= '0;
                borrow_reg[s] <= 1'b0;
                ovf_reg[s]    <= 1'b0;
            end
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_reg[s]  <= src_valid[s];
                a_reg[s]      <= src_a[s];
                nb_reg[s]     <= src_nb[s];
                diff_reg[s]   <= diff_next[s];
                borrow_reg[s] <= ~cout_next[s];
                ovf_reg[s]    <= ovf_next[s];
            end
        end
    end

    assign bus.o_valid    = valid_reg[STAGES-1];
    assign bus.o_diff     = diff_reg[STAGES-1];
    assign bus.o_borrow   = borrow_reg[STAGES-1];
    assign bus.o_overflow = ovf_reg[STAGES-1];
endmodule

// File: doc/math_subtractor_pipelined_cla.md
# math_subtractor_pipelined_cla

Pipelined N-bit subtractor computing `i_a - i_b - i_borrow`. It splits the word into CHUNK-bit slices and resolves one slice per stage with a carry-lookahead borrow chain, registering the inter-slice borrow between stages. It is the subtract/borrow counterpart to the existing CLA adder, for datapaths whose full-width single-cycle borrow chain misses timing. Throughput is one operation per clock, with a valid/ready handshake on both sides.

## Interface
- N, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits resolved per pipeline stage; STAGES = N/CHUNK (≥1).

- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_a  input  N  minuend, unsigned or two's complement.
- i_b  input  N  subtrahend.
- i_borrow  input  1  borrow-in, subtracted at bit 0.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result this cycle.
- o_diff  output  N  (i_a - i_b - i_borrow) mod 2^N.
- o_borrow  output  1  unsigned borrow-out: 1 iff i_a < i_b + i_borrow.
- o_overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB, in the a + ~b + ~borrow form.

## Operation
- Arithmetic is a + ~b + c0, with c0 = ~i_borrow, evaluated as a CLA on each slice:
  - g = a & ~b
  - p = a | ~b
  - c[i+1] = g[i] | (p[i] & c[i])
  - diff[i] = a[i] ^ ~b[i] ^ c[i]
- Final borrow = ~carry_out(MSB).
- Stage s (0..STAGES-1):
  - Resolves bits [s*CHUNK +: CHUNK] using the carry registered by stage s-1 (stage 0 uses c0).
  - Registers the slice result, the carry-out, and its valid bit.
  - Forwards the untouched upper a/~b bits (skew registers) and the already-computed lower diff bits (deskew registers).
- The last stage register is the output: o_diff, o_borrow, o_overflow, o_valid.
- o_overflow is computed in the last stage from the carry into bit N-1 and the carry out of bit N-1.
- Flow control is a global enable: en = i_ready | ~o_valid; o_ready = en.
  - When en=1, every stage shifts by one, and stage 0 loads {i_valid, operands}.
  - When en=0, all stages hold.
  - Internal bubbles are not collapsed.
- A beat is accepted when i_valid & o_ready and delivered when o_valid & i_ready.
- Results leave in acceptance order; no beat is dropped or duplicated.
- STAGES=1 degenerates to a full-width CLA with one output register; the handshake is unchanged.
- N % CHUNK != 0 or CHUNK < 1 is a configuration error: elaboration-time assertion, not run-time behaviour.

## Timing
- Reset (async assert, released synchronously by the surrounding reset logic):
  - All stage valid bits = 0.
  - o_valid=0, o_diff=0, o_borrow=0, o_overflow=0.
  - o_ready=1 in the first cycle after reset.
- Latency: a beat accepted at edge k is visible on the outputs after edge k+STAGES-1 (STAGES edges including the accepting edge), provided no stall occurs in between. With N=32 and CHUNK=8, the result appears 4 edges after acceptance.
- Each stall cycle (o_valid=1, i_ready=0) adds exactly one cycle to the latency of every in-flight beat.
- While o_valid=1 and i_ready=0, the outputs are held stable.
- o_ready is combinational from i_ready and o_valid; there is no combinational path from i_valid to o_ready.
- Simultaneous accept and deliver in the same cycle is legal, giving full throughput.
- Reset asserted mid-operation:
  - All in-flight beats are discarded immediately.
  - Outputs return to their reset values asynchronously.
- Critical path: one CHUNK-bit CLA slice plus carry register setup.

## Test plan
- N=32, CHUNK=8, i_ready=1: i_a=0x00000005, i_b=0x00000003, i_borrow=0 -> after 4 edges: o_diff=0x00000002, o_borrow=0, o_overflow=0.
- Borrow ripples across all stages: i_a=0x00000000, i_b=0x00000001 -> o_diff=0xFFFFFFFF, o_borrow=1, o_overflow=0.
- Signed overflow: i_a=0x80000000, i_b=0x00000001 -> o_diff=0x7FFFFFFF, o_borrow=0, o_overflow=1.
- Borrow-in: i_a=i_b=0x12345678, i_borrow=1 -> o_diff=0xFFFFFFFF, o_borrow=1, o_overflow=0.
- Back-to-back beats 1..8 with i_ready low for 3 cycles mid-stream:
  - o_ready=0 and o_diff held throughout the stall.
  - All 8 results are delivered in order, each matching a reference model.
  - Throughput returns to 1 per clock after the stall.
- i_rst pulsed while 3 beats are in flight -> outputs cleared immediately and the in-flight beats are never delivered; the next accepted beat completes correctly after 4 edges.
